top_if: RTL and testbench
=========================

// Module: top_if
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline; directly feeds top_id.
//  Holds the PC and a word-addressed instruction RAM. The debug unit loads the RAM while the
//  pipeline is disabled. Selects between PC+1 and the branch target returned by ID, and
//  drives the IF/ID latch (instruction, PC+1). A halt opcode freezes fetch until reset.
// PARAMETERS
//  LENGTH_INSTRUCTION  32           instruction / RAM word width
//  CANT_BITS_ADDR      11           PC and RAM address width; RAM depth = 2**CANT_BITS_ADDR words
//  HALT_OPCODE         32'hFFFFFFFF instruction word that stops fetch
// PORTS
//  i_clock            in   1     single clock; all state updates on posedge
//  i_soft_reset       in   1     asynchronous, active-high reset
//  i_enable_pipeline  in   1     1 = pipeline advances this cycle (run/step from debug unit)
//  i_stall            in   1     hazard stall from hazard unit; holds PC and IF/ID latch
//  i_branch_control   in   1     branch/jump taken, from ID
//  i_branch_dir       in   ADDR  branch/jump target word address, from ID
//  i_write_mem        in   1     program-load write strobe
//  i_addr_mem         in   ADDR  program-load word address
//  i_data_mem         in   32    program-load data
//  o_instruction      out  32    IF/ID latched instruction -> top_id.i_instruction
//  o_out_adder_pc     out  ADDR  IF/ID latched PC+1 -> top_id.i_out_adder_pc
//  o_pc               out  ADDR  current PC register (debug readout)
//  o_halt             out  1     1 once HALT_OPCODE has been latched into IF/ID
// BEHAVIOUR
//  Reset (async, any time, including mid-load or mid-run):
//   - pc=0, o_instruction=0 (NOP), o_out_adder_pc=0, o_halt=0, FSM state=RUN.
//   - RAM contents are NOT cleared.
//  Addressing:
//   - PC is a word address. pc+1 is computed modulo 2**ADDR, so 0x7FF+1 wraps to 0x000.
//  FSM, 2 states:
//   - RUN -> HALTED when a word equal to HALT_OPCODE is latched into o_instruction.
//   - HALTED -> RUN only on reset.
//  Advance condition: adv = (state==RUN) & i_enable_pipeline & ~i_stall.
//  When adv=1, on posedge:
//   - o_instruction <= ram[pc]; o_out_adder_pc <= pc+1.
//   - pc <= i_branch_control ? i_branch_dir : pc+1.
//   - No flush on branch: the instruction already in IF/ID is the delay slot and proceeds.
//  When adv=0, on posedge:
//   - pc, o_instruction and o_out_adder_pc hold.
//   - i_branch_control is ignored; ID re-presents the branch once the stall clears.
//  Latency:
//   - ram[pc] appears on o_instruction one posedge after pc holds that value.
//   - A taken branch is visible in pc one posedge after i_branch_control is sampled high.
//  HALTED state:
//   - pc, o_instruction (=HALT_OPCODE) and o_out_adder_pc freeze; o_halt=1.
//   - The halt word then propagates through top_id as a NOP-class instruction.
//  Priority: reset > HALTED > stall or enable low > branch > increment.
//  Program load:
//   - ram[i_addr_mem] <= i_data_mem on posedge when i_write_mem=1 and i_enable_pipeline=0.
//   - i_write_mem is ignored while i_enable_pipeline=1.
//  Fetch read and load write to the same address in the same cycle: read returns the old word.
//  The RAM is inferable as single-clock block RAM: one synchronous write port and one
//  synchronous read port.
// TESTING
//  1. Load 0x20010005 @0, 0x20020003 @1, HALT @2; enable.
//     -> o_instruction 0x20010005, 0x20020003, 0xFFFFFFFF on successive posedges;
//        o_out_adder_pc 1, 2, 3; o_halt=1; pc frozen at 3 for 10 further cycles.
//  2. Set pc=5 and pulse i_branch_control with i_branch_dir=0x040 for one cycle.
//     -> next latch holds ram[5] (delay slot), then ram[0x040], with o_out_adder_pc=0x041.
//  3. Hold i_stall=1 for 3 cycles at pc=7, with i_branch_control=1 during the stall.
//     -> pc and IF/ID are unchanged for 3 cycles, the branch is ignored, fetch resumes at ram[7].
//  4. Preload pc=0x7FF (all RAM non-halt) and run.
//     -> o_out_adder_pc=0x000 and the next fetch is ram[0].
//  5. Assert reset asynchronously mid-run (between clock edges) and while HALTED.
//     -> all outputs clear to 0 immediately, state=RUN, RAM unchanged; first fetch after release is ram[0].
//  6. Pulse i_write_mem with i_enable_pipeline=1.
//     -> RAM is unchanged (verified by a readback fetch).

Source files
------------

// File: rtl/top_if.sv
// Instruction-fetch stage: PC register, word-addressed instruction RAM and the IF/ID latch.
// The debug unit loads the RAM while the pipeline is disabled; a halt word freezes fetch
// until reset.
module top_if #(
    parameter int unsigned                LENGTH_INSTRUCTION = 32,
    parameter int unsigned                CANT_BITS_ADDR     = 11,
    parameter logic [LENGTH_INSTRUCTION-1:0] HALT_OPCODE     = 32'hFFFFFFFF
) (
    input  logic                          i_clock,
    input  logic                          i_soft_reset,
    input  logic                          i_enable_pipeline,
    input  logic                          i_stall,
    input  logic                          i_branch_control,
    input  logic [CANT_BITS_ADDR-1:0]     i_branch_dir,
    input  logic                          i_write_mem,
    input  logic [CANT_BITS_ADDR-1:0]     i_addr_mem,
    input  logic [LENGTH_INSTRUCTION-1:0] i_data_mem,
    output logic [LENGTH_INSTRUCTION-1:0] o_instruction,
    output logic [CANT_BITS_ADDR-1:0]     o_out_adder_pc,
    output logic [CANT_BITS_ADDR-1:0]     o_pc,
    output logic                          o_halt
);

    localparam int unsigned DEPTH = 1 << CANT_BITS_ADDR;

    typedef enum logic {StRun, StHalted} state_e;

    state_e                          state_q;
    logic [CANT_BITS_ADDR-1:0]       pc_q;
    logic [CANT_BITS_ADDR-1:0]       adder_q;
    logic                            valid_q;
    logic [LENGTH_INSTRUCTION-1:0]   rd_q;
    logic [LENGTH_INSTRUCTION-1:0]   ram [DEPTH];

    logic [CANT_BITS_ADDR-1:0]       pc_plus1;
    logic                            halt_now;
    logic                            halted;
    logic                            adv;

    // PC increment wraps naturally at the address width.
    assign pc_plus1 = pc_q + 1'b1;

    // The RAM read register has no reset (block-RAM friendly); valid_q masks it to a NOP
    // until the first fetch after reset, which also makes the output clear asynchronously.
    assign halt_now = valid_q && (rd_q == HALT_OPCODE);
    // Halt takes effect on the same edge the halt word is latched, so fetch stops at once.
    assign halted   = (state_q == StHalted) || halt_now;
    assign adv      = !halted && i_enable_pipeline && !i_stall;

    assign o_instruction  = valid_q ? rd_q : '0;
    assign o_out_adder_pc = adder_q;
    assign o_pc           = pc_q;
    assign o_halt         = halted;

    // Fetch FSM, PC and IF/ID PC+1 latch.
    always_ff @(posedge i_clock or posedge i_soft_reset) begin
        if (i_soft_reset) begin
            state_q <= StRun;
            pc_q    <= '0;
            adder_q <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun:    if (halt_now) state_q <= StHalted;
                StHalted: state_q <= StHalted;
                default:  state_q <= StRun;
            endcase
            if (adv) begin
                pc_q    <= i_branch_control ? i_branch_dir : pc_plus1;
                adder_q <= pc_plus1;
                valid_q <= 1'b1;
            end
        end
    end

    // Instruction RAM: one synchronous write port (program load), one synchronous read port.
    always_ff @(posedge i_clock) begin
        if (i_write_mem && !i_enable_pipeline) begin
            ram[i_addr_mem] <= i_data_mem;
        end
        if (adv) begin
            rd_q <= ram[pc_q];
        end
    end

endmodule

// File: tb/tb_top_if.sv
// Directed self-checking bench for the instruction-fetch stage.
module tb_top_if;

    logic        i_clock = 1'b0;
    logic        i_soft_reset;
    logic        i_enable_pipeline;
    logic        i_stall;
    logic        i_branch_control;
    logic [10:0] i_branch_dir;
    logic        i_write_mem;
    logic [10:0] i_addr_mem;
    logic [31:0] i_data_mem;
    logic [31:0] o_instruction;
    logic [10:0] o_out_adder_pc;
    logic [10:0] o_pc;
    logic        o_halt;

    int n_checks = 0;
    int n_errors = 0;

    top_if dut (
        .i_clock          (i_clock),
        .i_soft_reset     (i_soft_reset),
        .i_enable_pipeline(i_enable_pipeline),
        .i_stall          (i_stall),
        .i_branch_control (i_branch_control),
        .i_branch_dir     (i_branch_dir),
        .i_write_mem      (i_write_mem),
        .i_addr_mem       (i_addr_mem),
        .i_data_mem       (i_data_mem),
        .o_instruction    (o_instruction),
        .o_out_adder_pc   (o_out_adder_pc),
        .o_pc             (o_pc),
        .o_halt           (o_halt)
    );

    always #5 i_clock = ~i_clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic load_word(input logic [10:0] addr, input logic [31:0] data);
        i_write_mem = 1'b1;
        i_addr_mem  = addr;
        i_data_mem  = data;
        step();
        i_write_mem = 1'b0;
    endtask

    task automatic check_if(input string tag, input logic [31:0] instr, input logic [10:0] adder,
                            input logic [10:0] pc);
        check_eq({tag, ".instr"}, o_instruction, instr);
        check_eq({tag, ".adder"}, {21'd0, o_out_adder_pc}, {21'd0, adder});
        check_eq({tag, ".pc"}, {21'd0, o_pc}, {21'd0, pc});
    endtask

    // Assert reset between clock edges and check outputs clear without a clock edge.
    task automatic async_reset(input string tag);
        @(posedge i_clock);
        #2;
        i_soft_reset = 1'b1;
        #1;
        check_if({tag, ".rst"}, 32'h0, 11'h0, 11'h0);
        check_eq({tag, ".rst.halt"}, {31'd0, o_halt}, 32'd0);
        #1;
        i_soft_reset = 1'b0;
    endtask

    initial begin
        i_soft_reset      = 1'b1;
        i_enable_pipeline = 1'b0;
        i_stall           = 1'b0;
        i_branch_control  = 1'b0;
        i_branch_dir      = '0;
        i_write_mem       = 1'b0;
        i_addr_mem        = '0;
        i_data_mem        = '0;
        #12;
        check_if("reset", 32'h0, 11'h0, 11'h0);
        check_eq("reset.halt", {31'd0, o_halt}, 32'd0);
        i_soft_reset = 1'b0;
        step();

        // Program image
        load_word(11'h000, 32'h20010005);
        load_word(11'h001, 32'h20020003);
        load_word(11'h002, 32'hFFFFFFFF);
        load_word(11'h005, 32'h55550005);
        load_word(11'h006, 32'h66660006);
        load_word(11'h007, 32'h77770007);
        load_word(11'h008, 32'h88880008);
        load_word(11'h040, 32'h40400040);
        load_word(11'h041, 32'h41410041);
        load_word(11'h7FF, 32'h7FF007FF);
        check_if("load.idle", 32'h0, 11'h0, 11'h0);

        // Sequential fetch up to the halt word
        i_enable_pipeline = 1'b1;
        step(); check_if("seq0", 32'h20010005, 11'h001, 11'h001);
        step(); check_if("seq1", 32'h20020003, 11'h002, 11'h002);
        step(); check_if("seq2", 32'hFFFFFFFF, 11'h003, 11'h003);
        check_eq("seq2.halt", {31'd0, o_halt}, 32'd1);
        for (int i = 0; i < 10; i++) step();
        check_if("halted", 32'hFFFFFFFF, 11'h003, 11'h003);
        check_eq("halted.halt", {31'd0, o_halt}, 32'd1);

        // Reset while halted, then reach pc=5 via a jump
        async_reset("rst_halted");
        i_branch_control = 1'b1;
        i_branch_dir     = 11'h005;
        step(); check_if("jmp5", 32'h20010005, 11'h001, 11'h005);
        check_eq("jmp5.halt", {31'd0, o_halt}, 32'd0);

        // Taken branch with delay slot
        i_branch_dir = 11'h040;
        step(); check_if("br.slot", 32'h55550005, 11'h006, 11'h040);
        i_branch_control = 1'b0;
        step(); check_if("br.tgt", 32'h40400040, 11'h041, 11'h041);

        // Stall with a branch asserted is ignored
        i_branch_control = 1'b1;
        i_branch_dir     = 11'h007;
        step(); check_if("jmp7", 32'h41410041, 11'h042, 11'h007);
        i_stall      = 1'b1;
        i_branch_dir = 11'h100;
        for (int i = 0; i < 3; i++) begin
            step(); check_if("stall", 32'h41410041, 11'h042, 11'h007);
        end
        i_stall          = 1'b0;
        i_branch_control = 1'b0;
        step(); check_if("resume", 32'h77770007, 11'h008, 11'h008);

        // PC wrap at top of the address space
        i_branch_control = 1'b1;
        i_branch_dir     = 11'h7FF;
        step(); check_if("jmp7ff", 32'h88880008, 11'h009, 11'h7FF);
        i_branch_control = 1'b0;
        step(); check_if("wrap", 32'h7FF007FF, 11'h000, 11'h000);
        step(); check_if("wrap.next", 32'h20010005, 11'h001, 11'h001);

        // Async reset mid-run; RAM preserved, first fetch is ram[0]
        async_reset("rst_run");
        step(); check_if("after_rst", 32'h20010005, 11'h001, 11'h001);

        // Write strobe ignored while the pipeline is enabled
        i_write_mem = 1'b1;
        i_addr_mem  = 11'h000;
        i_data_mem  = 32'hDEADBEEF;
        step(); check_if("wr_en", 32'h20020003, 11'h002, 11'h002);
        i_write_mem = 1'b0;
        async_reset("rst_wr");
        step(); check_if("readback", 32'h20010005, 11'h001, 11'h001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
